// File: rtl/mdu_pkg.sv
// Shared encodings, default latencies and counter sizing for the EX-stage multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MADD  = 3'd4,
    MDU_MADDU = 3'd5
  } mdu_op_e;

  typedef enum logic {ST_IDLE, ST_RUN} mdu_state_e;

  // Result captured at launch; wr=0 means leave HI/LO untouched at completion.
  typedef struct packed {
    logic        wr;
    logic [31:0] hi;
    logic [31:0] lo;
  } mdu_res_t;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  function automatic int mdu_cnt_w(input int m, input int d);
    int mx;
    mx = (m > d) ? m : d;
    return (mx > 1) ? $clog2(mx) : 1;
  endfunction

  localparam int MDU_CNT_W = mdu_cnt_w(MDU_MULT_CYCLES, MDU_DIV_CYCLES);

endpackage

// File: rtl/mdu_signed_div.sv
// 32-bit combinational divide: quotient truncates toward zero, remainder follows the dividend's sign.
module mdu_signed_div import mdu_pkg::*; (
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] quo,
  output logic [31:0] rem,
  output logic        div_by_zero
);

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag;

  always_comb begin
    a_neg       = is_signed & a[31];
    b_neg       = is_signed & b[31];
    div_by_zero = (b == 32'd0);
    a_mag       = a_neg ? (32'd0 - a) : a;
    // Substitute 1 for a zero divisor so the datapath never sees x/0; caller discards the result.
    b_mag       = div_by_zero ? 32'd1 : (b_neg ? (32'd0 - b) : b);
    q_mag       = a_mag / b_mag;
    r_mag       = a_mag % b_mag;
    quo         = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem         = a_neg ? (32'd0 - r_mag) : r_mag;
  end

endmodule

// File: rtl/ex_mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO; result lands after a fixed latency.
// Define MDU_MADD_EN to enable MADD/MADDU (ops 4/5) accumulating into {HI,LO}.
module ex_mdu import mdu_pkg::*; #(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = mdu_cnt_w(MULT_CYCLES, DIV_CYCLES);
  localparam logic [CW-1:0] MULT_LAST = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV_CYCLES - 1);

  mdu_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  mdu_res_t      pend_q, pend_d;

  logic          op_legal, is_div;
  logic [63:0]   prod_s, prod_u;
  logic [31:0]   quo, rem;
  logic          div_by_zero;
  mdu_res_t      res;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  mdu_signed_div u_div (
    .is_signed   (op == MDU_DIV),
    .a           (a),
    .b           (b),
    .quo         (quo),
    .rem         (rem),
    .div_by_zero (div_by_zero)
  );

  always_comb begin
    is_div = (op == MDU_DIV) || (op == MDU_DIVU);
    case (op)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: op_legal = 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU:                    op_legal = 1'b1;
`endif
      default:                                op_legal = 1'b0;
    endcase

    res = '{wr: 1'b1, hi: prod_s[63:32], lo: prod_s[31:0]};
    case (op)
      MDU_MULTU:          {res.hi, res.lo} = prod_u;
      MDU_DIV, MDU_DIVU:  res = '{wr: ~div_by_zero, hi: rem, lo: quo};
`ifdef MDU_MADD_EN
      MDU_MADD:           {res.hi, res.lo} = {hi_q, lo_q} + prod_s;
      MDU_MADDU:          {res.hi, res.lo} = {hi_q, lo_q} + prod_u;
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    pend_d  = pend_q;
    case (state_q)
      ST_IDLE: begin
        if (start && op_legal) begin
          state_d = ST_RUN;
          busy_d  = 1'b1;
          cnt_d   = is_div ? DIV_LAST : MULT_LAST;
          pend_d  = res;
        end else begin
          if (hi_we) hi_d = a;
          if (lo_we) lo_d = a;
        end
      end
      ST_RUN: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          if (pend_q.wr) begin
            hi_d = pend_q.hi;
            lo_d = pend_q.lo;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      pend_q  <= pend_d;
    end
  end

  assign busy      = busy_q;
  assign stall_req = busy_q | start;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule
